// File: rtl/apb_cfg_master_if.sv
// rtl/apb_cfg_master_if.sv - APB3 configuration bus signal bundle
interface apb_cfg_master_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_cfg_master.sv
// rtl/apb_cfg_master.sv - APB3 config initiator with command FIFO; ACCESS watchdog under APB_CFG_MASTER_TIMEOUT_EN
module apb_cfg_master #(
    parameter int CMD_DEPTH_LOG2 = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    apb_cfg_master_if.master m_apb,
    output logic             busy
);
    localparam int DEPTH = 1 << CMD_DEPTH_LOG2;
    localparam int PW    = CMD_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state, state_n;
    logic [64:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop, done, abort, tmo_hit;
    logic [64:0]   head;
    logic [31:0]   paddr_q, pwdata_q;
    logic          pwrite_q;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_mem[rd_ptr[PW-2:0]];

    assign m_apb.paddr   = paddr_q;
    assign m_apb.pwrite  = pwrite_q;
    assign m_apb.pwdata  = pwdata_q;
    assign m_apb.psel    = (state == SETUP) || (state == ACCESS);
    assign m_apb.penable = (state == ACCESS);
    assign rsp_valid     = (state == RESP);
    assign busy          = !empty || (state != IDLE);

`ifdef APB_CFG_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt, tmo_cnt_inc;

    assign tmo_cnt_inc = tmo_cnt + 1'b1;
    assign tmo_hit     = (tmo_cnt_inc == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!resetn || state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !m_apb.pready) begin
            tmo_cnt <= tmo_cnt_inc;
        end
    end
`else
    // Watchdog compiled out: ACCESS waits for pready indefinitely.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                // A completing pready wins over a watchdog expiry in the same cycle.
                if (m_apb.pready) begin
                    done    = 1'b1;
                    state_n = RESP;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-2:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pwrite_q <= head[64];
                paddr_q  <= head[63:32];
                pwdata_q <= head[31:0];
            end
            if (done) begin
                rsp_rdata <= pwrite_q ? 32'h0 : m_apb.prdata;
                rsp_err   <= m_apb.pslverr;
            end else if (abort) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_cfg_master.sv
// tb/tb_apb_cfg_master.sv - scoreboard bench for apb_cfg_master with a scripted APB slave
`timescale 1ns/1ps
module tb_apb_cfg_master;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] prdata;
        logic        slverr;
    } plan_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;

    plan_t       plan_q[$];
    logic [32:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    apb_cfg_master_if apb();

    apb_cfg_master #(.CMD_DEPTH_LOG2(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_apb     (apb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int stall, input logic [31:0] prd, input logic serr, input bit tmo);
        plan_t p;
        bit    ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("push_accepted", 64'(ok), 64'd1);
        if (ok) begin
            p.addr = a; p.write = w; p.wdata = d; p.stall = stall; p.prdata = prd; p.slverr = serr;
            plan_q.push_back(p);
            exp_q.push_back(tmo ? {1'b1, 32'h0} : {serr, (w ? 32'h0 : prd)});
        end
    endtask

    task automatic wait_drain(input string tag);
        bit drained = 1'b0;
        for (int i = 0; i < 400 && !drained; i++) begin
            @(negedge clk);
            drained = (exp_q.size() == 0) && (plan_q.size() == 0) && !busy;
        end
        check(tag, 64'(drained), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Scripted APB slave: each SETUP consumes one plan entry.
    initial begin : slave
        plan_t cur;
        bit    active;
        int    rem, acc;
        active = 1'b0; rem = 0; acc = 0;
        apb.pready = 1'b0; apb.prdata = 32'h0; apb.pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                active = 1'b0;
                apb.pready = 1'b0;
            end else if (apb.psel && !apb.penable) begin
                check("setup_planned", 64'(plan_q.size() > 0), 64'd1);
                if (plan_q.size() > 0) begin
                    cur = plan_q.pop_front();
                    active = 1'b1; rem = cur.stall; acc = 0;
                    check("setup_addr", 64'(apb.paddr), 64'(cur.addr));
                    check("setup_write", 64'(apb.pwrite), 64'(cur.write));
                    check("setup_wdata", 64'(apb.pwdata), 64'(cur.wdata));
                end
                apb.pready = 1'b0;
            end else if (apb.psel && apb.penable && active) begin
                acc++;
                check("access_addr", 64'(apb.paddr), 64'(cur.addr));
                check("access_write", 64'(apb.pwrite), 64'(cur.write));
                if (rem == 0) begin
                    apb.pready = 1'b1; apb.prdata = cur.prdata; apb.pslverr = cur.slverr;
                    active = 1'b0;
                    check("access_cycles", 64'(acc), 64'(cur.stall + 1));
                end else begin
                    rem--;
                    apb.pready = 1'b0; apb.prdata = 32'h1234_5678; apb.pslverr = 1'b0;
                end
            end else begin
                if (active && acc > 0) begin
                    check("timeout_cycles", 64'(acc), 64'(TMO));
                    active = 1'b0;
                end
                apb.pready = 1'b0; apb.pslverr = 1'b0;
            end
        end
    end

    initial begin : consumer
        logic [32:0] e, held;
        bit          hold;
        hold = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                    check("rsp_hold_data", 64'({rsp_err, rsp_rdata}), 64'(held));
                end
                if (rsp_valid && rsp_ready) begin
                    check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
                        check("rsp_err", 64'(rsp_err), 64'(e[32]));
                    end
                end
                hold = rsp_valid && !rsp_ready;
                held = {rsp_err, rsp_rdata};
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int seen;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_psel", 64'(apb.psel), 64'd0);
        check("rst_penable", 64'(apb.penable), 64'd0);
        check("rst_pwrite", 64'(apb.pwrite), 64'd0);
        check("rst_paddr", 64'(apb.paddr), 64'd0);
        check("rst_pwdata", 64'(apb.pwdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Write 0x4 <- 0x1F with zero wait states; check exact phase timing.
        push_cmd(1'b1, 32'h4, 32'h1F, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_idle_psel", 64'(apb.psel), 64'd0);
        check("t1_idle_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_setup", 64'({apb.psel, apb.penable}), 64'b10);
        @(negedge clk);
        check("t1_access", 64'({apb.psel, apb.penable}), 64'b11);
        check("t1_paddr", 64'(apb.paddr), 64'h4);
        check("t1_pwrite", 64'(apb.pwrite), 64'd1);
        check("t1_pwdata", 64'(apb.pwdata), 64'h1F);
        @(negedge clk);
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_psel_off", 64'(apb.psel), 64'd0);
        wait_drain("t1_drain");

        // Read 0x8 with three wait states.
        push_cmd(1'b0, 32'h8, 32'h0, 3, 32'hA5A5_A5A5, 1'b0, 1'b0);
        wait_drain("t2_drain");

        // Slave error, then a normal command.
        push_cmd(1'b1, 32'h0, 32'h55, 0, 32'h0, 1'b1, 1'b0);
        push_cmd(1'b1, 32'h8, 32'h7, 1, 32'h0, 1'b0, 1'b0);
        wait_drain("t3_drain");

        // Five commands against a depth-4 FIFO while responses are stalled.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'b1, 32'((i % 3) * 4), 32'(i + 16), i % 2, 32'h0, 1'b0, 1'b0);
        end
        repeat (4) begin
            @(negedge clk);
            check("t4_cmd_ready_full", 64'(cmd_ready), 64'd0);
            check("t4_busy", 64'(busy), 64'd1);
        end
        check("t4_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_drain("t4_drain");

        // Reset during the second ACCESS cycle of a stalled read with another command queued.
        push_cmd(1'b0, 32'h8, 32'h0, 10, 32'h1111_2222, 1'b0, 1'b0);
        push_cmd(1'b1, 32'h4, 32'h9, 0, 32'h0, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            @(negedge clk);
            if (apb.psel && apb.penable) seen++;
        end
        check("t5_reached_access", 64'(seen), 64'd2);
        resetn = 1'b0;
        @(negedge clk);
        check("t5_psel", 64'(apb.psel), 64'd0);
        check("t5_penable", 64'(apb.penable), 64'd0);
        check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        plan_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_no_rsp", 64'(rsp_valid), 64'd0);
            check("t5_no_psel", 64'(apb.psel), 64'd0);
        end
        @(posedge clk);
        #1;
        push_cmd(1'b1, 32'h4, 32'h3, 0, 32'h0, 1'b0, 1'b0);
        wait_drain("t5_recover_drain");

`ifdef APB_CFG_MASTER_TIMEOUT_EN
        // Slave never answers: watchdog abandons after TMO stalled cycles.
        push_cmd(1'b0, 32'h8, 32'h0, 100, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_drain("t6_timeout_drain");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_cfg_master.md
# apb_cfg_master

APB3 initiator that turns queued register-access commands from the accelerator's control sequencer into APB transfers on the configuration bus. It drives the accelerator's write-only configuration registers: 0x0 weight transfer, 0x4 last active row, 0x8 last active column. It buffers commands in a small FIFO, runs one APB transfer at a time (SETUP then ACCESS, with wait states), and returns one response per command.

## Interface
- CMD_DEPTH_LOG2, 2: command FIFO depth is 2^CMD_DEPTH_LOG2 entries.
- TIMEOUT_CYCLES, 64: ACCESS-phase watchdog limit in cycles. Used only when the timeout feature is compiled in.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command (not full)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  captured PRDATA (0 for writes)
- rsp_err  out  1  PSLVERR or timeout
- m_apb_paddr  out  32  PADDR
- m_apb_psel  out  1  PSEL
- m_apb_penable  out  1  PENABLE
- m_apb_pwrite  out  1  PWRITE
- m_apb_pwdata  out  32  PWDATA
- m_apb_pready  in  1  PREADY
- m_apb_prdata  in  32  PRDATA
- m_apb_pslverr  in  1  PSLVERR
- busy  out  1  FIFO non-empty or transfer/response outstanding

## Operation
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full.
  - Pointers are CMD_DEPTH_LOG2+1 bits wide (wrap bit): full when indices match and wrap bits differ; empty when the pointers are equal.
  - Simultaneous push and pop while full is not permitted. Pop occurs only in IDLE, where a push and a pop in the same cycle leave the count unchanged.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the m_apb_paddr/pwrite/pwdata registers and go to SETUP.
  - SETUP: psel=1, penable=0; always go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1. When pready=1, capture prdata (forced to 0 if pwrite) and pslverr into rsp_rdata/rsp_err, then go to RESP. Otherwise stay in ACCESS.
  - RESP: psel=0, rsp_valid=1. On rsp_ready go to IDLE.
- APB outputs:
  - paddr, pwrite and pwdata are held stable from SETUP through the ACCESS cycle in which pready is sampled high.
  - They keep their last value in IDLE/RESP.
- busy = !empty || state != IDLE.
- Responses are returned in command order, exactly one per command.

## Timing
- Reset values: state IDLE, FIFO empty, cmd_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, psel 0, penable 0, pwrite 0, paddr 0, pwdata 0, busy 0.
- Command pushed at cycle t into an empty FIFO with the FSM in IDLE:
  - t+1: IDLE pops the command.
  - t+2: SETUP.
  - t+3: first ACCESS.
  - With pready=1 at t+3: rsp_valid=1 at t+4.
- Each pready=0 cycle adds one cycle of latency.
- Back-to-back throughput with rsp_ready held high: one transfer every 4 cycles (IDLE, SETUP, ACCESS, RESP).
- rsp_valid, once asserted, holds with stable data until rsp_ready. The FSM does not start the next transfer until then.
- Reset asserted mid-transfer: all state returns to reset values next edge. psel drops immediately (synchronous), queued commands are discarded, no response is produced.

## Configuration
- APB_CFG_MASTER_TIMEOUT_EN defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - If it reaches TIMEOUT_CYCLES with pready still 0, the transfer is abandoned: go to RESP with rsp_err=1 and rsp_rdata=0, and drop psel/penable.
  - pready=1 in the same cycle as the limit takes priority and completes normally.
- Not defined: no counter; ACCESS waits indefinitely for pready.

## Test plan
- Write 0x4 data 0x0000001F, pready tied 1 -> APB SETUP at t+2, ACCESS at t+3 with paddr=0x4, pwrite=1, pwdata=0x1F; rsp_valid at t+4 with rsp_err=0, rsp_rdata=0.
- Read 0x8 with pready low 3 cycles, prdata=0xA5A5A5A5 on completion -> 4 ACCESS cycles, address stable throughout; rsp_rdata=0xA5A5A5A5.
- Write with pslverr=1 at completion -> rsp_err=1; next command proceeds normally.
- Push 5 commands with depth 4 and rsp_ready=0 -> the FSM pops the first; the remaining four fill the FIFO and cmd_ready=0 from then on. Releasing rsp_ready drains the commands in order with addresses 0x0, 0x4, 0x8, 0x0, 0x4.
- Deassert resetn during the second ACCESS cycle of a stalled read -> psel=0, penable=0, cmd_ready=1, busy=0 next cycle; no rsp_valid.
- With APB_CFG_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready held 0 -> psel drops after 8 stalled cycles; rsp_err=1, rsp_rdata=0.
